axis_pixel_binarizer_packer: RTL and testbench

- Upstream feeder for the TCB classifier AXI4-Stream wrapper in the Fashion-MNIST flow.
- Accepts an 8-bit greyscale pixel stream from DMA and binarizes each pixel against a threshold.
- Packs the bits LSB-first into 32-bit words and zero-pads each image to exactly NUMBER_OF_OUTPUT_WORDS words.
- Marks the final word with m_axis_last, so every image arrives downstream as one fixed-length 32-word frame.

---
 rtl/axis_pixel_binarizer_packer_pkg.sv | 28 ++
 rtl/axis_pixel_binarizer_packer_if.sv | 13 +
 rtl/axis_pixel_binarizer_packer_out_reg_slice.sv | 44 ++++
 rtl/axis_pixel_binarizer_packer.sv | 185 ++++++++++++++++++
 tb/tb_axis_pixel_binarizer_packer.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pixel_binarizer_packer_pkg.sv
// Shared constants, state encoding and sizing helper for the pixel binarizer/packer
// and the classifier wrapper it feeds.
package axis_pixel_binarizer_packer_pkg;

  localparam int unsigned PIX_WIDTH_DEF              = 8;
  localparam int unsigned DATA_WIDTH_DEF             = 32;
  localparam int unsigned NUM_PIXELS_DEF             = 784;
  localparam int unsigned NUMBER_OF_OUTPUT_WORDS_DEF = 32;
  localparam int unsigned THRESHOLD_DEF              = 128;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'b00,
    ST_PAD    = 2'b01,
    ST_DROP   = 2'b10
  } state_e;

  // Bits needed to hold 0..v-1 (at least 1).
  function automatic int unsigned clogb2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/axis_pixel_binarizer_packer_if.sv
// AXI4-Stream style handshake bundle (valid/data/last/ready).
// master: drives valid/data/last, samples ready. slave: the reverse.
interface axis_pixel_binarizer_packer_if #(
  parameter int unsigned W = 8
);
  logic         valid;
  logic [W-1:0] data;
  logic         last;
  logic         ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/axis_pixel_binarizer_packer_out_reg_slice.sv
// axis_out_reg_slice: single-entry registered output stage.
// Ports: clk_i, rst_ni (sync, active-low), load_i/data_i/last_i (word to load),
//        free_c (register can accept a word this cycle), m_axis (master stream).
module axis_out_reg_slice
  import axis_pixel_binarizer_packer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  output logic                  free_c,
  axis_pixel_binarizer_packer_if.master m_axis
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  last_q;

  // Free when empty or draining this edge, so load and drain can overlap.
  assign free_c = !valid_q || m_axis.ready;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i && free_c) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (m_axis.ready) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign m_axis.valid = valid_q;
  assign m_axis.data  = data_q;
  assign m_axis.last  = last_q;

endmodule

// File: rtl/axis_pixel_binarizer_packer.sv
// axis_pixel_binarizer_packer: thresholds an 8-bit pixel stream into bits, packs
// them LSB-first into words and zero-pads every image to a fixed-length frame.
// Ports: axi_clk, axi_reset_n (sync, active-low), s_axis (pixel stream in),
//        m_axis (packed word stream out, last on final word of each frame).
// Optional PACKER_STATS_EN: adds img_count, short_count, long_count (saturating).
module axis_pixel_binarizer_packer
  import axis_pixel_binarizer_packer_pkg::*;
#(
  parameter int unsigned PIX_WIDTH              = PIX_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH             = DATA_WIDTH_DEF,
  parameter int unsigned NUM_PIXELS             = NUM_PIXELS_DEF,
  parameter int unsigned NUMBER_OF_OUTPUT_WORDS = NUMBER_OF_OUTPUT_WORDS_DEF,
  parameter int unsigned THRESHOLD              = THRESHOLD_DEF
) (
  input  logic axi_clk,
  input  logic axi_reset_n,
  axis_pixel_binarizer_packer_if.slave  s_axis,
  axis_pixel_binarizer_packer_if.master m_axis
`ifdef PACKER_STATS_EN
  ,
  output logic [15:0] img_count,
  output logic [15:0] short_count,
  output logic [15:0] long_count
`endif
);

  localparam int unsigned PCW = clogb2(NUM_PIXELS);
  localparam int unsigned BCW = clogb2(DATA_WIDTH);
  localparam int unsigned WCW = clogb2(NUMBER_OF_OUTPUT_WORDS);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0]        word_cnt_q, word_cnt_d;
  logic [PCW-1:0]        pix_cnt_q, pix_cnt_d;
  logic                  drop_pend_q, drop_pend_d;

  logic                  free_c;
  logic                  s_ready_c;
  logic                  accept_c;
  logic                  load_c;
  logic [DATA_WIDTH-1:0] ld_data_c;
  logic                  ld_last_c;

  logic                  pix_bit_c;
  logic [DATA_WIDTH-1:0] acc_new_c;
  logic                  at_np_c;
  logic                  word_full_c;
  logic                  last_word_c;

  assign pix_bit_c   = (s_axis.data >= PIX_WIDTH'(THRESHOLD));
  assign acc_new_c   = pix_bit_c ? (acc_q | (DATA_WIDTH'(1) << bit_cnt_q)) : acc_q;
  assign at_np_c     = (pix_cnt_q == PCW'(NUM_PIXELS - 1));
  assign word_full_c = (bit_cnt_q == BCW'(DATA_WIDTH - 1));
  assign last_word_c = (word_cnt_q == WCW'(NUMBER_OF_OUTPUT_WORDS - 1));

  // Ready is held low throughout reset regardless of state.
  assign s_axis.ready = s_ready_c && axi_reset_n;

  // State and counter registers.
  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      state_q     <= ST_ACCEPT;
      acc_q       <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      pix_cnt_q   <= '0;
      drop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      drop_pend_q <= drop_pend_d;
    end
  end

  // Next-state, packing and output-register load control.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    drop_pend_d = drop_pend_q;
    s_ready_c   = 1'b0;
    accept_c    = 1'b0;
    load_c      = 1'b0;
    ld_data_c   = '0;
    ld_last_c   = 1'b0;

    unique case (state_q)
      ST_ACCEPT: begin
        s_ready_c = free_c;
        if (s_axis.valid && free_c) begin
          accept_c  = 1'b1;
          pix_cnt_d = pix_cnt_q + PCW'(1);
          if (word_full_c || at_np_c || s_axis.last) begin
            load_c     = 1'b1;
            ld_data_c  = acc_new_c;
            acc_d      = '0;
            bit_cnt_d  = '0;
            word_cnt_d = word_cnt_q + WCW'(1);
          end else begin
            acc_d     = acc_new_c;
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
          if (at_np_c || s_axis.last) begin
            pix_cnt_d = '0;
            if (last_word_c) begin
              // Image filled the whole frame: no padding needed.
              ld_last_c  = 1'b1;
              word_cnt_d = '0;
              state_d    = s_axis.last ? ST_ACCEPT : ST_DROP;
            end else begin
              // Reaching the pixel limit without last means the tail must be dropped.
              drop_pend_d = !s_axis.last;
              state_d     = ST_PAD;
            end
          end
        end
      end

      ST_PAD: begin
        if (free_c) begin
          load_c     = 1'b1;
          word_cnt_d = word_cnt_q + WCW'(1);
          if (last_word_c) begin
            ld_last_c   = 1'b1;
            word_cnt_d  = '0;
            drop_pend_d = 1'b0;
            state_d     = drop_pend_q ? ST_DROP : ST_ACCEPT;
          end
        end
      end

      ST_DROP: begin
        s_ready_c = 1'b1;
        if (s_axis.valid && s_axis.last) state_d = ST_ACCEPT;
      end

      default: state_d = ST_ACCEPT;
    endcase
  end

  axis_out_reg_slice #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clk_i  (axi_clk),
    .rst_ni (axi_reset_n),
    .load_i (load_c),
    .data_i (ld_data_c),
    .last_i (ld_last_c),
    .free_c (free_c),
    .m_axis (m_axis)
  );

`ifdef PACKER_STATS_EN
  logic [15:0] img_cnt_q, short_cnt_q, long_cnt_q;
  logic        ev_frame_c, ev_short_c, ev_long_c;

  assign ev_frame_c = load_c && ld_last_c;
  assign ev_short_c = accept_c && s_axis.last && !at_np_c;
  assign ev_long_c  = (state_d == ST_DROP) && (state_q != ST_DROP);

  // Saturating event counters.
  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      img_cnt_q   <= '0;
      short_cnt_q <= '0;
      long_cnt_q  <= '0;
    end else begin
      if (ev_frame_c && img_cnt_q != 16'hFFFF)   img_cnt_q   <= img_cnt_q + 16'd1;
      if (ev_short_c && short_cnt_q != 16'hFFFF) short_cnt_q <= short_cnt_q + 16'd1;
      if (ev_long_c && long_cnt_q != 16'hFFFF)   long_cnt_q  <= long_cnt_q + 16'd1;
    end
  end

  assign img_count   = img_cnt_q;
  assign short_count = short_cnt_q;
  assign long_count  = long_cnt_q;
`endif

endmodule

// File: tb/tb_axis_pixel_binarizer_packer.sv
// Self-checking bench: frame-level model of binarize/pack/pad versus DUT output stream.
module tb_axis_pixel_binarizer_packer;

  localparam int NP  = 784;
  localparam int NW  = 32;
  localparam int DW  = 32;
  localparam int THR = 128;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_pixel_binarizer_packer_if #(.W(8))  s_if ();
  axis_pixel_binarizer_packer_if #(.W(32)) m_if ();

`ifdef PACKER_STATS_EN
  logic [15:0] img_count, short_count, long_count;
`endif

  axis_pixel_binarizer_packer dut (
    .axi_clk     (clk),
    .axi_reset_n (rst_n),
    .s_axis      (s_if),
    .m_axis      (m_if)
`ifdef PACKER_STATS_EN
    ,
    .img_count   (img_count),
    .short_count (short_count),
    .long_count  (long_count)
`endif
  );

  int    n_cmp = 0;
  int    n_err = 0;
  int    pix [0:1023];
  word_t exp_q[$];
  word_t rec_q[$];
  bit    bp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
    end
  endtask

  // Expected frame from the first n pixels of pix[]: threshold, LSB-first, pad to NW words.
  task automatic push_frame(input int n);
    word_t w;
    for (int wi = 0; wi < NW; wi++) begin
      w.d = '0;
      for (int b = 0; b < DW; b++) begin
        int idx;
        idx = wi * DW + b;
        if (idx < n && idx < NP && pix[idx] >= THR) w.d[b] = 1'b1;
      end
      w.l = (wi == NW - 1);
      exp_q.push_back(w);
    end
  endtask

  // Downstream ready driver plus per-cycle output check.
  logic        stall_prev = 1'b0;
  logic [31:0] stall_d;
  logic        stall_l;
  always @(negedge clk) begin
    word_t e;
    m_if.ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    if (stall_prev && rst_n) begin
      chk("stall_valid", 32'(m_if.valid), 32'd1);
      chk("stall_data", m_if.data, stall_d);
      chk("stall_last", 32'(m_if.last), 32'(stall_l));
    end
    if (rst_n && m_if.valid && m_if.ready) begin
      e.d = m_if.data;
      e.l = m_if.last;
      rec_q.push_back(e);
      if (exp_q.size() == 0) begin
        chk("unexpected_word", m_if.data, 32'hDEADDEAD);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", m_if.data, e.d);
        chk("word_last", 32'(m_if.last), 32'(e.l));
      end
    end
    stall_prev = rst_n && m_if.valid && !m_if.ready;
    stall_d    = m_if.data;
    stall_l    = m_if.last;
  end

  task automatic send_pix(input int v, input bit l, output int waits);
    waits = 0;
    @(negedge clk);
    s_if.valid = 1'b1;
    s_if.data  = 8'(v);
    s_if.last  = l;
    forever begin
      #1;
      if (s_if.ready) begin
        @(posedge clk);
        break;
      end
      @(negedge clk);
      waits++;
      if (waits > 3000) begin
        chk("ready_timeout", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  task automatic send_image(input int n, input bit with_last, input int chk_from);
    int w;
    for (int i = 0; i < n; i++) begin
      send_pix(pix[i], with_last && (i == n - 1), w);
      if (chk_from >= 0 && i > chk_from) chk("drop_ready_wait", 32'(w), 32'd0);
    end
    @(negedge clk);
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 5000) begin
      @(negedge clk);
      c++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (5) @(negedge clk);
  endtask

  function automatic int count_last();
    int c;
    c = 0;
    foreach (rec_q[i]) if (rec_q[i].l) c++;
    return c;
  endfunction

  initial begin
    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.last  = 1'b0;
    m_if.ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_m_valid", 32'(m_if.valid), 32'd0);
    chk("rst_m_last", 32'(m_if.last), 32'd0);
    chk("rst_m_data", m_if.data, 32'd0);
    chk("rst_s_ready", 32'(s_if.ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_s_ready", 32'(s_if.ready), 32'd1);

    // 1: full white image
    rec_q.delete();
    for (int i = 0; i < NP; i++) pix[i] = 255;
    push_frame(NP);
    chk("model_t1_w0", exp_q[0].d, 32'hFFFFFFFF);
    chk("model_t1_w24", exp_q[24].d, 32'h0000FFFF);
    chk("model_t1_w25", exp_q[25].d, 32'h00000000);
    send_image(NP, 1'b1, -1);
    wait_drain();
    chk("t1_nwords", 32'(rec_q.size()), 32'd32);
    chk("t1_w23", rec_q[23].d, 32'hFFFFFFFF);
    chk("t1_w24", rec_q[24].d, 32'h0000FFFF);
    chk("t1_nlast", 32'(count_last()), 32'd1);
    chk("t1_last31", 32'(rec_q[31].l), 32'd1);

    // 2: threshold boundary 127/128 alternating
    rec_q.delete();
    for (int i = 0; i < NP; i++) pix[i] = (i % 2 == 0) ? 127 : 128;
    push_frame(NP);
    chk("model_t2_w0", exp_q[0].d, 32'hAAAAAAAA);
    send_image(NP, 1'b1, -1);
    wait_drain();
    chk("t2_w5", rec_q[5].d, 32'hAAAAAAAA);

    // 3: short image of 40 pixels
    rec_q.delete();
    for (int i = 0; i < 40; i++) pix[i] = 200;
    push_frame(40);
    chk("model_t3_w1", exp_q[1].d, 32'h000000FF);
    send_image(40, 1'b1, -1);
    wait_drain();
    chk("t3_nwords", 32'(rec_q.size()), 32'd32);
    chk("t3_w0", rec_q[0].d, 32'hFFFFFFFF);
    chk("t3_w1", rec_q[1].d, 32'h000000FF);
    chk("t3_w2", rec_q[2].d, 32'h00000000);
    chk("t3_last31", 32'(rec_q[31].l), 32'd1);

    // 4: over-long image, tail dropped, then a normal image
    rec_q.delete();
    for (int i = 0; i < 790; i++) pix[i] = (i % 3 == 0) ? 200 : 10;
    push_frame(790);
    send_image(790, 1'b1, 784);
    wait_drain();
    chk("t4_nwords", 32'(rec_q.size()), 32'd32);
`ifdef PACKER_STATS_EN
    chk("stat_img", 32'(img_count), 32'd4);
    chk("stat_short", 32'(short_count), 32'd1);
    chk("stat_long", 32'(long_count), 32'd1);
`endif
    rec_q.delete();
    for (int i = 0; i < NP; i++) pix[i] = (i % 5 == 1) ? 128 : 0;
    push_frame(NP);
    send_image(NP, 1'b1, -1);
    wait_drain();
    chk("t4b_nwords", 32'(rec_q.size()), 32'd32);

    // 5: random backpressure on white image
    rec_q.delete();
    bp_en = 1'b1;
    for (int i = 0; i < NP; i++) pix[i] = 255;
    push_frame(NP);
    send_image(NP, 1'b1, -1);
    wait_drain();
    bp_en = 1'b0;
    chk("t5_nwords", 32'(rec_q.size()), 32'd32);

    // 6: reset after 300 pixels, then a full image
    rec_q.delete();
    for (int i = 0; i < 9; i++) begin
      word_t w;
      w.d = 32'hFFFFFFFF;
      w.l = 1'b0;
      exp_q.push_back(w);
    end
    send_image(300, 1'b0, -1);
    wait_drain();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_s_ready", 32'(s_if.ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_rst_m_valid", 32'(m_if.valid), 32'd0);
    repeat (20) @(negedge clk);
    chk("t6_no_partial", 32'(rec_q.size()), 32'd9);
    rec_q.delete();
    push_frame(NP);
    send_image(NP, 1'b1, -1);
    wait_drain();
    chk("t6_nwords", 32'(rec_q.size()), 32'd32);
    chk("t6_w24", rec_q[24].d, 32'h0000FFFF);

    chk("final_exp_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
